// File: rtl/starboy_pkg.sv
// Shared types and helpers for the piece scheduler.
// block_t enumerates the seven playable pieces; LFSR_TAPS is the feedback
// mask of the right-shifting 8-bit Galois LFSR used by the bag randomiser.
package starboy_pkg;

  typedef enum logic [2:0] {
    BLOCK_L     = 3'd0,
    BLOCK_J     = 3'd1,
    BLOCK_I     = 3'd2,
    BLOCK_O     = 3'd3,
    BLOCK_T     = 3'd4,
    BLOCK_Z     = 3'd5,
    BLOCK_STEPS = 3'd6
  } block_t;

  localparam int         NUM_BLOCKS = 7;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  // One LFSR step: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] n;
    if (v[0]) begin
      n = (v >> 1) ^ LFSR_TAPS;
    end else begin
      n = v >> 1;
    end
    return n;
  endfunction

  // Number of set bits in a bag mask (0..7).
  function automatic logic [2:0] popcount7(input logic [6:0] m);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      cnt = cnt + {2'b00, m[i]};
    end
    return cnt;
  endfunction

  // First type not yet used in the bag, scanning cand, cand+1, ... mod 7.
  // The caller guarantees at least one clear bit, so the scan always hits.
  function automatic logic [2:0] first_free(input logic [6:0] mask,
                                            input logic [2:0] cand);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    idx   = cand;
    res   = cand;
    found = 1'b0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      if (!found && !mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res   = res;
      end
      if (idx == 3'd6) begin
        idx = 3'd0;
      end else begin
        idx = idx + 3'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bag_generator.sv
// 7-bag randomiser.
// Holds the LFSR and the used-type mask. o_piece is the piece that would be
// generated this cycle; when i_gen_en is high the mask records it and the
// LFSR steps. The LFSR only moves on generate, so the piece order depends on
// nothing but the seed.
// Ports:
//   clk, rst_i        clock, async active-high reset
//   i_gen_en          consume o_piece this cycle
//   o_piece           next piece of the current bag
//   o_bag_remaining   types not yet generated in the current bag (0..7)
module bag_generator
  import starboy_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       i_gen_en,
  output logic [2:0] o_piece,
  output logic [2:0] o_bag_remaining
);

  logic [7:0]            r_lfsr;
  logic [NUM_BLOCKS-1:0] r_mask;
  logic [2:0]            w_cand;
  logic [NUM_BLOCKS-1:0] w_mask_set;

  // Candidate from the LFSR low bits (7 folds onto 0), then the wrap scan.
  always_comb begin
    if (r_lfsr[2:0] == 3'd7) begin
      w_cand = 3'd0;
    end else begin
      w_cand = r_lfsr[2:0];
    end
    o_piece    = first_free(r_mask, w_cand);
    w_mask_set = r_mask | (7'd1 << o_piece);
  end

  // LFSR and bag mask; a completed bag clears on the same edge.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= LFSR_SEED;
      r_mask <= {NUM_BLOCKS{1'b0}};
    end else if (i_gen_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
      r_mask <= (&w_mask_set) ? {NUM_BLOCKS{1'b0}} : w_mask_set;
    end
  end

  assign o_bag_remaining = 3'd7 - popcount7(r_mask);

endmodule

// File: rtl/piece_scheduler.sv
// Chooses the next piece to spawn and hands it to the game FSM.
// Auto mode pops the head of a preview queue that the bag generator keeps
// topped up; manual mode issues the button-driven selection instead.
// Ports:
//   clk, rst_i        clock, async active-high reset
//   button_i          debounced select button (rising edge advances select_o)
//   manual_i          1 = manual pick, 0 = auto bag (sampled in issue cycle)
//   spawn_req_i       level request for the next piece
//   spawn_ack_o       1-cycle pulse, spawn_block_o valid with it
//   spawn_block_o     issued piece
//   preview_o         queue contents, [2:0] = head
//   preview_valid_o   queue full
//   select_o          current manual selection
//   bag_remaining_o   types left in the current bag
module piece_scheduler
  import starboy_pkg::*;
#(
  parameter int         PREVIEW_DEPTH = 3,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       button_i,
  input  logic                       manual_i,
  input  logic                       spawn_req_i,
  output logic                       spawn_ack_o,
  output logic [2:0]                 spawn_block_o,
  output logic [3*PREVIEW_DEPTH-1:0] preview_o,
  output logic                       preview_valid_o,
  output logic [2:0]                 select_o,
  output logic [2:0]                 bag_remaining_o
);

  logic [2:0] r_q [PREVIEW_DEPTH];
  logic [2:0] r_count;
  logic       r_ack;
  logic [2:0] r_spawn;
  logic [2:0] r_select;
  logic       r_btn_prev;

  logic       w_gen_en;
  logic       w_issue;
  logic       w_pop;
  logic [2:0] w_piece;
  logic [2:0] w_tail;
  logic [2:0] w_count_nxt;
  logic [2:0] w_shift [PREVIEW_DEPTH];
  logic [2:0] w_q_nxt [PREVIEW_DEPTH];

  bag_generator #(
    .LFSR_SEED (LFSR_SEED)
  ) u_bag (
    .clk             (clk),
    .rst_i           (rst_i),
    .i_gen_en        (w_gen_en),
    .o_piece         (w_piece),
    .o_bag_remaining (bag_remaining_o)
  );

  // Generate whenever there is room, even on a pop edge; issue only when
  // not already acking so a held request acks every other cycle.
  always_comb begin
    w_gen_en = (r_count < 3'(PREVIEW_DEPTH));
    w_issue  = spawn_req_i && !r_ack && (manual_i || (r_count != 3'd0));
    w_pop    = w_issue && !manual_i;
  end

  // Next queue contents: optional shift, then tail push at the post-pop slot.
  always_comb begin
    w_shift[PREVIEW_DEPTH-1] = 3'd0;
    for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
      w_shift[i] = r_q[i+1];
    end
    if (w_pop) begin
      w_tail = r_count - 3'd1;
    end else begin
      w_tail = r_count;
    end
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      if (w_gen_en && (3'(i) == w_tail)) begin
        w_q_nxt[i] = w_piece;
      end else if (w_pop) begin
        w_q_nxt[i] = w_shift[i];
      end else begin
        w_q_nxt[i] = r_q[i];
      end
    end
    case ({w_pop, w_gen_en})
      2'b10:   w_count_nxt = r_count - 3'd1;
      2'b01:   w_count_nxt = r_count + 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue, handshake and manual selection state.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PREVIEW_DEPTH; i++) begin
        r_q[i] <= 3'd0;
      end
      r_count    <= 3'd0;
      r_ack      <= 1'b0;
      r_spawn    <= BLOCK_L;
      r_select   <= BLOCK_L;
      r_btn_prev <= 1'b0;
    end else begin
      r_q        <= w_q_nxt;
      r_count    <= w_count_nxt;
      r_ack      <= w_issue;
      r_btn_prev <= button_i;
      if (w_issue) begin
        // r_select is still the pre-increment value on a same-cycle press.
        r_spawn <= manual_i ? r_select : r_q[0];
      end
      if (button_i && !r_btn_prev) begin
        r_select <= (r_select == 3'd6) ? 3'd0 : (r_select + 3'd1);
      end
    end
  end

  // Flatten the queue for the preview port, head in the low bits.
  always_comb begin
    preview_o = {(3*PREVIEW_DEPTH){1'b0}};
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      preview_o[3*i +: 3] = r_q[i];
    end
  end

  assign preview_valid_o = (r_count == 3'(PREVIEW_DEPTH));
  assign spawn_ack_o     = r_ack;
  assign spawn_block_o   = r_spawn;
  assign select_o        = r_select;

endmodule

// File: tb/tb_piece_scheduler.sv
// Scoreboard bench for piece_scheduler: stimulus pushes the expected piece
// for every issue; a monitor pops and compares on each spawn_ack_o.
module tb_piece_scheduler;

  logic       clk;
  logic       rst_i;
  logic       button_i;
  logic       manual_i;
  logic       spawn_req_i;
  logic       spawn_ack_o;
  logic [2:0] spawn_block_o;
  logic [8:0] preview_o;
  logic       preview_valid_o;
  logic [2:0] select_o;
  logic [2:0] bag_remaining_o;

  int         n_checks;
  int         n_errors;
  logic [2:0] exp_q [$];

  // First two bags from seed 8'hA5, hand-stepped through the LFSR.
  logic [2:0] bag_seq [14] = '{3'd5, 3'd2, 3'd6, 3'd3, 3'd1, 3'd0, 3'd4,
                               3'd6, 3'd3, 3'd1, 3'd0, 3'd2, 3'd4, 3'd5};
  logic [2:0] sel_seq [8]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
  logic       held_ack [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  piece_scheduler #(
    .PREVIEW_DEPTH (3),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .button_i        (button_i),
    .manual_i        (manual_i),
    .spawn_req_i     (spawn_req_i),
    .spawn_ack_o     (spawn_ack_o),
    .spawn_block_o   (spawn_block_o),
    .preview_o       (preview_o),
    .preview_valid_o (preview_valid_o),
    .select_o        (select_o),
    .bag_remaining_o (bag_remaining_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the request with the expected piece queued; drop it once acked.
  task automatic issue(input logic [2:0] exp, input int gap);
    logic got;
    exp_q.push_back(exp);
    spawn_req_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!got) begin
        tick(1);
        if (spawn_ack_o === 1'b1) got = 1'b1;
      end
    end
    spawn_req_i = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL issue_timeout: got no ack in 20 cycles, expected ack for piece %0d", exp);
      void'(exp_q.pop_back());
    end
    tick(gap);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Monitor: every ack must match the oldest expected piece.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (spawn_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spawn_unexpected: got ack with block %0d, expected no ack", spawn_block_o);
        end else begin
          e = exp_q.pop_front();
          chk("spawn_block", {29'd0, spawn_block_o}, {29'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    button_i    = 1'b0;
    manual_i    = 1'b0;
    spawn_req_i = 1'b0;
    rst_i       = 1'b1;

    // Reset values and fill timing.
    tick(2);
    chk("rst_ack",     {31'd0, spawn_ack_o}, 32'd0);
    chk("rst_block",   {29'd0, spawn_block_o}, 32'd0);
    chk("rst_preview", {23'd0, preview_o}, 32'd0);
    chk("rst_valid",   {31'd0, preview_valid_o}, 32'd0);
    chk("rst_select",  {29'd0, select_o}, 32'd0);
    chk("rst_bag",     {29'd0, bag_remaining_o}, 32'd7);
    @(negedge clk);
    rst_i = 1'b0;
    tick(2);
    chk("fill_valid_early", {31'd0, preview_valid_o}, 32'd0);
    tick(1);
    chk("fill_valid",   {31'd0, preview_valid_o}, 32'd1);
    chk("fill_preview", {23'd0, preview_o}, 32'h195);
    chk("fill_bag",     {29'd0, bag_remaining_o}, 32'd4);

    // Two full bags, tight spacing.
    for (int i = 0; i < 14; i++) issue(bag_seq[i], 0);
    tick(4);
    chk("bags_preview", {23'd0, preview_o}, 32'h0C6);
    chk("bags_bag",     {29'd0, bag_remaining_o}, 32'd4);

    // Same seed, wide spacing: identical sequence.
    do_reset();
    tick(3);
    chk("reseed_preview", {23'd0, preview_o}, 32'h195);
    for (int i = 0; i < 14; i++) issue(bag_seq[i], 4);
    tick(4);
    chk("spaced_preview", {23'd0, preview_o}, 32'h0C6);

    // Held request on a full queue: ack every other cycle.
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd3);
    spawn_req_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("held_ack", {31'd0, spawn_ack_o}, {31'd0, held_ack[k]});
      if (k < 5) tick(1);
    end
    spawn_req_i = 1'b0;
    tick(3);
    chk("held_valid",   {31'd0, preview_valid_o}, 32'd1);
    chk("held_preview", {23'd0, preview_o}, 32'h055);
    chk("held_bag",     {29'd0, bag_remaining_o}, 32'd1);

    // Manual selection counter with wrap.
    manual_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      button_i = 1'b1;
      tick(1);
      button_i = 1'b0;
      tick(1);
      chk("select_step", {29'd0, select_o}, {29'd0, sel_seq[i]});
    end
    button_i = 1'b1;
    tick(5);
    button_i = 1'b0;
    tick(1);
    chk("select_held", {29'd0, select_o}, 32'd2);
    issue(3'd2, 2);
    chk("manual_preview", {23'd0, preview_o}, 32'h055);
    chk("manual_bag",     {29'd0, bag_remaining_o}, 32'd1);
    // Press and request together: pre-increment selection is issued.
    button_i = 1'b1;
    issue(3'd2, 0);
    button_i = 1'b0;
    tick(1);
    chk("select_after_combo", {29'd0, select_o}, 32'd3);

    // Back to auto: queue untouched by manual activity.
    manual_i = 1'b0;
    issue(3'd5, 3);
    chk("auto_preview", {23'd0, preview_o}, 32'h10A);
    chk("auto_bag_wrap", {29'd0, bag_remaining_o}, 32'd7);

    // Reset in the ack cycle.
    spawn_req_i = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (!got) begin
          tick(1);
          if (spawn_ack_o === 1'b1) got = 1'b1;
        end
      end
      chk("rst_mid_ack_seen", {31'd0, got}, 32'd1);
    end
    rst_i = 1'b1;
    #1;
    chk("rst_mid_ack",   {31'd0, spawn_ack_o}, 32'd0);
    chk("rst_mid_block", {29'd0, spawn_block_o}, 32'd0);
    chk("rst_mid_bag",   {29'd0, bag_remaining_o}, 32'd7);
    spawn_req_i = 1'b0;
    tick(2);
    @(negedge clk);
    rst_i = 1'b0;
    tick(3);
    chk("rerun_head",    {29'd0, preview_o[2:0]}, 32'd5);
    chk("rerun_preview", {23'd0, preview_o}, 32'h195);

    tick(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
